// File: rtl/video_in_store.sv
// Pixel FIFO to frame-buffer writer: pops packed 32-bit pixel words and
// stores them through single Wishbone writes into two alternating frame buffers.
module video_in_store #(
  parameter int p_WIDTH  = 640,
  parameter int p_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        enable,
  input  logic [31:0] base_addr0,
  input  logic [31:0] base_addr1,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_data,
  output logic        fifo_r_e,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        buf_sel,
  output logic        frame_done,
  output logic        err_o
);

  localparam int WORDS = p_WIDTH * p_HEIGHT / 4;
  localparam logic [16:0] LAST_IDX = 17'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t      state_q, state_d;
  logic        re_q, re_d;
  logic        bus_q, bus_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [16:0] idx_q, idx_d;
  logic        buf_q, buf_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  always_comb begin
    state_d = state_q;
    re_d    = 1'b0;
    bus_d   = 1'b0;
    sel_d   = 4'h0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = RD;
          re_d    = 1'b1;
        end
      end
      RD: state_d = CAP;
      CAP: begin
        state_d = WR;
        bus_d   = 1'b1;
        sel_d   = 4'hF;
        dat_d   = fifo_data;
        adr_d   = (buf_q ? base_addr1 : base_addr0)
                + {13'd0, idx_q, 2'b00};
      end
      WR: begin
        if (wb_ack_i || wb_err_i) begin
          state_d = IDLE;
          // an errored word is dropped but still consumes its slot
          if (wb_err_i) err_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            buf_d  = ~buf_q;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + 17'd1;
          end
        end else begin
          bus_d = 1'b1;
          sel_d = 4'hF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      re_q    <= 1'b0;
      bus_q   <= 1'b0;
      sel_q   <= 4'h0;
      adr_q   <= '0;
      dat_q   <= '0;
      idx_q   <= '0;
      buf_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      re_q    <= re_d;
      bus_q   <= bus_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign fifo_r_e   = re_q;
  assign wb_cyc_o   = bus_q;
  assign wb_stb_o   = bus_q;
  assign wb_we_o    = bus_q;
  assign wb_sel_o   = sel_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign buf_sel    = buf_q;
  assign frame_done = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_video_in_store.sv
// Bench for video_in_store: FIFO model, Wishbone responder,
// table of write vectors plus directed multi-cycle sequences.
module tb_video_in_store;

  logic        clk, RST, enable;
  logic [31:0] base_addr0, base_addr1;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_r_e;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic        wb_ack_i, wb_err_i;
  logic        buf_sel, frame_done, err_o;

  video_in_store #(.p_WIDTH(8), .p_HEIGHT(2)) dut (
    .clk(clk), .RST(RST), .enable(enable),
    .base_addr0(base_addr0), .base_addr1(base_addr1),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_e(fifo_r_e),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .buf_sel(buf_sel), .frame_done(frame_done), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_re    = 0;
  int n_wr    = 0;
  int ack_wait = 0;
  bit err_next = 0;
  bit tog_en   = 0;
  bit phase    = 0;
  bit re_seen  = 0;
  logic prev_empty = 1'b1;
  logic [31:0] q[$];
  logic [31:0] rec_adr[$];
  logic [31:0] rec_dat[$];

  typedef struct {
    logic [31:0] data;
    int          wt;
    bit          err;
    logic [31:0] adr;
    logic        eo;
    logic        bs;
    logic        fd;
  } vec_t;
  vec_t tv[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // synchronous-read FIFO model, optional forced-empty toggling
  initial begin
    fifo_data  = '0;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      re_seen = fifo_r_e;
      @(posedge clk);
      #1;
      if (re_seen && q.size() > 0) fifo_data = q.pop_front();
      phase = ~phase;
      fifo_empty = (q.size() == 0) || (tog_en && phase);
    end
  end

  // Wishbone slave with programmable wait states
  initial begin
    int wc;
    wc = 0;
    wb_ack_i = 0;
    wb_err_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (wb_ack_i || wb_err_i) begin
        wb_ack_i = 0;
        wb_err_i = 0;
        wc = 0;
      end else if (!wb_stb_o) begin
        wc = 0;
      end else if (wc >= ack_wait) begin
        if (err_next) wb_err_i = 1;
        else wb_ack_i = 1;
      end else begin
        wc++;
      end
    end
  end

  always @(negedge clk) begin
    if (fifo_r_e) begin
      n_re++;
      chk("re_after_empty", {31'd0, prev_empty}, 32'd0);
      chk("re_fifo_has_data", {31'd0, q.size() > 0}, 32'd1);
    end
    if (wb_stb_o && (wb_ack_i || wb_err_i)) begin
      rec_adr.push_back(wb_adr_o);
      rec_dat.push_back(wb_dat_o);
      n_wr++;
      chk("sel", {28'd0, wb_sel_o}, 32'hF);
      chk("cyc_we", {30'd0, wb_cyc_o, wb_we_o}, 32'd3);
    end
    prev_empty = fifo_empty;
  end

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    q.push_back(d);
  endtask

  task automatic wait_wr(input int start);
    bit ok;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (n_wr > start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("write_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    RST = 1;
    repeat (2) @(negedge clk);
    RST = 0;
  endtask

  initial begin
    int lat, w0, r0;
    bit seen;
    RST = 1;
    enable = 0;
    base_addr0 = 32'h1000;
    base_addr1 = 32'h2000;
    tv[0] = '{32'hAABBCCDD, 2, 0, 32'h1000, 0, 0, 0};
    tv[1] = '{32'h11111111, 0, 1, 32'h1004, 1, 0, 0};
    tv[2] = '{32'h22222222, 1, 0, 32'h1008, 1, 0, 0};
    tv[3] = '{32'h33333333, 0, 0, 32'h100C, 1, 1, 1};
    tv[4] = '{32'h44444444, 0, 0, 32'h2000, 1, 1, 0};
    tv[5] = '{32'h55555555, 3, 0, 32'h2004, 1, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_bus", {28'd0, fifo_r_e, wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    chk("rst_sel", {28'd0, wb_sel_o}, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_flags", {29'd0, buf_sel, frame_done, err_o}, 0);
    RST = 0;

    // single word, 2 wait states, latency to strobe
    push(32'hAABBCCDD);
    repeat (3) @(negedge clk);
    r0 = n_re;
    w0 = n_wr;
    ack_wait = 2;
    enable = 1;
    lat = 0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (wb_stb_o) begin
        seen = 1;
        break;
      end
    end
    chk("stb_seen", {31'd0, seen}, 1);
    chk("latency", lat, 3);
    wait_wr(w0);
    chk("one_re", n_re - r0, 1);
    chk("first_adr", rec_adr[$], 32'h1000);
    chk("first_dat", rec_dat[$], 32'hAABBCCDD);
    @(negedge clk);
    chk("stb_low_after", {31'd0, wb_stb_o}, 0);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      ack_wait = tv[i].wt;
      err_next = tv[i].err;
      w0 = n_wr;
      push(tv[i].data);
      wait_wr(w0);
      chk($sformatf("v%0d_adr", i), rec_adr[$], tv[i].adr);
      chk($sformatf("v%0d_dat", i), rec_dat[$], tv[i].data);
      chk($sformatf("v%0d_err_o", i), {31'd0, err_o}, {31'd0, tv[i].eo});
      chk($sformatf("v%0d_buf", i), {31'd0, buf_sel}, {31'd0, tv[i].bs});
      chk($sformatf("v%0d_done", i), {31'd0, frame_done},
          {31'd0, tv[i].fd});
    end
    err_next = 0;

    // reset while the write is stalled on the bus
    ack_wait = 50;
    push(32'h66666666);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wb_stb_o) begin
        seen = 1;
        break;
      end
    end
    chk("rst_wr_stb_seen", {31'd0, seen}, 1);
    RST = 1;
    #1;
    chk("rst_wr_drop", {30'd0, wb_stb_o, wb_cyc_o}, 0);
    @(negedge clk);
    RST = 0;
    ack_wait = 0;
    w0 = n_wr;
    push(32'h77777777);
    wait_wr(w0);
    chk("post_rst_adr", rec_adr[$], 32'h1000);
    chk("post_rst_dat", rec_dat[$], 32'h77777777);
    chk("post_rst_flags", {30'd0, buf_sel, err_o}, 0);

    // enable dropped during capture
    enable = 0;
    push(32'h01010101);
    push(32'h02020202);
    push(32'h03030303);
    r0 = n_re;
    w0 = n_wr;
    @(negedge clk);
    enable = 1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_r_e) begin
        seen = 1;
        break;
      end
    end
    @(negedge clk);
    enable = 0;
    repeat (20) @(negedge clk);
    chk("en_re_once", n_re - r0, 1);
    chk("en_wr_once", n_wr - w0, 1);
    chk("en_dat", rec_dat[$], 32'h01010101);
    enable = 1;
    repeat (30) @(negedge clk);
    chk("en_re_all", n_re - r0, 3);
    chk("en_wr_all", n_wr - w0, 3);
    chk("en_last_dat", rec_dat[$], 32'h03030303);
    chk("en_last_adr", rec_adr[$], 32'h100C);

    // empty flag toggling every cycle, zero-wait ack
    tog_en = 1;
    r0 = n_re;
    w0 = n_wr;
    for (int i = 0; i < 6; i++) push(32'hC0DE0000 + i);
    repeat (100) @(negedge clk);
    chk("tog_wr_count", n_wr - w0, 6);
    chk("tog_re_count", n_re - r0, 6);
    chk("tog_last_dat", rec_dat[$], 32'hC0DE0005);
    chk("tog_fifo_drained", q.size(), 0);
    tog_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_in_store.md
VIDEO_IN_STORE -- requirements
Module: video_in_store

Parameters
REQ-001 The module SHALL have parameter p_WIDTH, default 640, meaning pixels per line.
REQ-002 The module SHALL have parameter p_HEIGHT, default 480, meaning lines per frame.
REQ-003 The module SHALL derive local constant WORDS = p_WIDTH*p_HEIGHT/4 (76800 at defaults), the number of 32-bit words per frame.

Interface
REQ-004 The module SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The module SHALL have these ports:
- clk  in  1  system clock (100 MHz)
- RST  in  1  asynchronous active-high reset
- enable  in  1  store permission
- base_addr0  in  32  byte address of frame buffer 0
- base_addr1  in  32  byte address of frame buffer 1
- fifo_empty  in  1  pixel FIFO empty
- fifo_data  in  32  FIFO read data; 4 packed pixels, pixel 0 in [31:24]
- fifo_r_e  out  1  FIFO read enable, one-cycle pulse
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write
- wb_sel_o  out  4  byte selects
- wb_adr_o  out  32  byte address
- wb_dat_o  out  32  write data
- wb_ack_i  in  1  Wishbone acknowledge
- wb_err_i  in  1  Wishbone error
- buf_sel  out  1  buffer currently being filled
- frame_done  out  1  one-cycle pulse, frame complete
- err_o  out  1  sticky bus-error flag

Function
REQ-006 FIFO read SHALL be synchronous: data is valid on fifo_data the cycle after fifo_r_e=1.
REQ-007 FSM states SHALL be IDLE, RD, CAP and WR; all outputs SHALL be registered.
REQ-008 IDLE: if enable=1 and fifo_empty=0, SHALL go to RD; otherwise SHALL stay in IDLE.
REQ-009 RD: fifo_r_e SHALL be 1 for exactly this one cycle; SHALL go to CAP.
REQ-010 CAP: fifo_data SHALL be latched into wb_dat_o at the end of the cycle; SHALL go to WR.
REQ-011 WR: wb_cyc_o, wb_stb_o and wb_we_o SHALL be 1 and wb_sel_o SHALL be 4'hF, held stable until wb_ack_i=1 or wb_err_i=1 is sampled; SHALL then return to IDLE, with cyc/stb/we low on the next cycle.
REQ-012 Ack in the first WR cycle SHALL be legal. Latency from IDLE (condition true) to stb high SHALL be 3 cycles; minimum throughput SHALL be 1 word per 4 cycles.
REQ-013 wb_adr_o SHALL equal (buf_sel ? base_addr1 : base_addr0) + 4*word_idx, computed mod 2^32 and latched in CAP.
REQ-014 word_idx SHALL be 17 bits, 0..WORDS-1, and SHALL increment on each terminated write (ack or err).
REQ-015 On the write terminated with word_idx = WORDS-1: word_idx SHALL wrap to 0, buf_sel SHALL toggle, and frame_done SHALL pulse 1 cycle, all on the same edge.
REQ-016 wb_err_i=1 SHALL terminate the write like an ack (word dropped, index still advances) and SHALL set err_o to 1; err_o SHALL be cleared only by RST.
REQ-017 If ack and err are sampled simultaneously, the write SHALL be treated as an error.
REQ-018 enable falling during RD, CAP or WR SHALL NOT abort the transfer; the FSM SHALL finish the write and then hold in IDLE with word_idx and buf_sel retained.
REQ-019 fifo_empty SHALL be sampled only in IDLE; the FSM SHALL never read an empty FIFO.
REQ-020 base_addr0/1 SHALL be sampled only in CAP; changes mid-frame SHALL apply from the next word.

Reset
REQ-021 RST=1 SHALL immediately force state IDLE, fifo_r_e=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, word_idx=0, buf_sel=0, frame_done=0 and err_o=0.
REQ-022 Reset asserted mid-write SHALL drop the bus cycle at once; the pending word SHALL be lost.

Verification
REQ-023 Bench SHALL check: base_addr0=0x1000, FIFO holds 0xAABBCCDD, ack after 2 wait cycles -> one r_e pulse, stb 3 cycles after non-empty, adr=0x1000, dat=0xAABBCCDD, sel=F.
REQ-024 Bench SHALL check: p_WIDTH=8, p_HEIGHT=2 (WORDS=4), 5 words, base1=0x2000 -> frame_done after the 4th ack, buf_sel=1, 5th adr=0x2000.
REQ-025 Bench SHALL check: wb_err_i on word 1 -> err_o=1 stays set, next adr = base+8, no retry.
REQ-026 Bench SHALL check: enable dropped in CAP with FIFO non-empty -> current write completes, no further r_e until enable=1.
REQ-027 Bench SHALL check: RST pulsed during WR with stb high -> stb/cyc low same cycle, next write after reset goes to base_addr0+0.
REQ-028 Bench SHALL check: fifo_empty toggling every cycle, zero-wait ack -> no r_e while empty, word count equals FIFO pushes.
